decode_stage: RTL
=================

# decode_stage

Parametrised instruction-decode stage with an internal register file and a registered ID/EX output slot. It sits between the IF/ID buffer and EX and adds valid/ready handshakes on both sides. It also adds load-use hazard stalls, flush, held-entry writeback refresh, optional hardwired-zero R0 and a stall counter. Branch target/select to IF stays same-cycle combinational.

## Interface
- DATA_W, 32: datapath width; must be ≥ 32.
- NUM_REGS, 16: register count; must be ≤ 16 because register fields are 4 bits.
- R0_ZERO, 1: 1 makes R0 read as 0 and ignores writes to it.
- CNT_W, 16: stall counter width.

- clk  in  1  clock
- rst_n  in  1  one clock; reset is synchronous and active-low
- in_valid  in  1  IF/ID entry valid
- in_ready  out  1  stage accepts the entry this cycle
- instr  in  32  instruction
- pc_plus_4  in  DATA_W  PC+4 of the entry
- interrupt  in  1  interrupt tag of the entry
- wr, wr_dst, wr_data  in  1/4/DATA_W  writeback port
- ex_valid, ex_mem_read, ex_reg_dst  in  1/1/4  EX-stage occupant info, used for load-use detection
- flush  in  1  squash the accepted entry and the held output
- out_valid  out  1  ID/EX slot valid
- out_ready  in  1  EX consumes the slot
- rd1, rd2  out  DATA_W  operand values
- rs1_idx, rs2_idx, reg_dst  out  4  source and destination indices
- sign_ext_imm, pc_plus_4_out  out  DATA_W  immediate and PC+4
- interrupt_out  out  1  registered interrupt tag
- ctrl_out  out  ctrl_t  decoded control bundle
- branch_pc  out  DATA_W  branch target to IF
- branch_sel  out  1  take branch_pc
- stall_cnt  out  CNT_W  saturating stall counter

## Operation
- **Fields:**
  - opcode = instr[31:27]
  - rs1 = instr[27:24]
  - rs2 = instr[23:20]
  - rd3 = instr[19:16]
  - The bit-27 overlap between opcode and rs1 is intentional.
- **Control:** `decode_ctrl(opcode)` from the package is the sole opcode map. It returns imm_sel, branch_type, branch_sel, reg_dst_sel, mem_read and reg_write.
- **Immediate:**
  - imm_sel 00: sign-extend instr[15:0]
  - imm_sel 01: sign-extend instr[18:0]
  - imm_sel 1x: sign-extend instr[26:0]
  - Extension is to DATA_W.
- **reg_dst:** reg_dst_sel 00 selects rs1, 01 selects rs2, 1x selects rd3.
- **Operand read:**
  - Register file read is asynchronous.
  - If wr is high and wr_dst equals the source index, the operand takes wr_data (WB bypass).
  - With R0_ZERO=1, index 0 always reads 0 and bypass from wr_dst=0 is suppressed.
- **Load-use hazard:** hz = in_valid & ex_valid & ex_mem_read & (ex_reg_dst==rs1 | ex_reg_dst==rs2).
- **Ready and fire:**
  - in_ready = rst_n & !flush & !hz & (!out_valid | out_ready)
  - fire = in_valid & in_ready
- **Slot update, in priority order:**
  1. flush: out_valid←0.
  2. fire: slot loads the decoded entry and out_valid←1.
  3. out_valid & out_ready: out_valid←0 (bubble).
  4. Otherwise the slot holds.
- **Held-entry refresh:**
  - Applies while the slot holds (out_valid & !out_ready & !fire).
  - A WB write with wr_dst==rs1_idx updates rd1; same for rs2_idx and rd2.
  - R0_ZERO rules apply.
- **Branch:**
  - branch_pc = sign_ext_imm + (branch_type ? pc_plus_4 : 0), computed mod 2^DATA_W.
  - branch_sel = fire & ctrl.branch_sel; it is never asserted on stall or flush.
- **stall_cnt:** increments each cycle with in_valid & !in_ready and saturates at all-ones.
- **Register file:** writes on the clk edge when wr is high; R0 writes are dropped when R0_ZERO=1.

## Timing
- **Reset** (sampled on clk while rst_n is low):
  - out_valid=0, all slot payload=0, all registers=0, stall_cnt=0.
  - in_ready and branch_sel are 0 throughout reset.
- **Latency:** fire in cycle N gives out_valid in N+1.
- **Throughput:** one instruction per cycle when out_ready is held high.
- **Load-use:** one bubble per hazard. The hazard clears once EX advances.
- **Flush:** the cycle after flush, out_valid=0; the incoming entry is dropped.
- **Write then read:** a WB write and a decode read of the same register in one cycle return wr_data.
- **Held operands:** rd1/rd2 of a held slot never go stale relative to writebacks.
- **Reset mid-stall:** reset overrides the stall; the slot empties and the counter clears.

## Structure
- **decode_pkg:**
  - ctrl_t struct
  - imm_sel and reg_dst_sel enums
  - REG_AW=4
  - field bit-position constants
  - decode_ctrl function
- **regfile_param:** sub-module, NUM_REGS×DATA_W, two async reads, one sync write, sync active-low clear, R0_ZERO handling.
- **decode_stage:** instantiates regfile_param once; bypass, hazard, slot, refresh and counter logic live in the top.

## Test plan
- **Reset, then one ALU instruction:**
  - Setup: reset, write R3=0x11, R4=0x22, then present an ALU instr with rs1=3, rs2=4 and out_ready=1.
  - Required: out_valid one cycle later, rd1=0x11, rd2=0x22.
- **Same-cycle WB bypass:**
  - Stimulus: wr=1, wr_dst=5, wr_data=0xABCD together with decode of rs1=5.
  - Required: rd1=0xABCD.
  - R0 check: with R0_ZERO=1 and wr_dst=0, rd1=0.
- **Load-use stall:**
  - Stimulus: ex_valid=1, ex_mem_read=1, ex_reg_dst=7 while an instruction with rs2=7 is presented.
  - Required: in_ready=0 and stall_cnt=1; after EX clears, the entry is accepted.
- **Backpressure refresh:**
  - Stimulus: slot holding rs1=2 with out_ready=0, then a WB write R2=0x55.
  - Required: held rd1=0x55 the next cycle and the slot is otherwise unchanged.
- **Branch:**
  - Stimulus: branch_type=1, pc_plus_4=0x100, imm=0xFFFC.
  - Required: branch_pc=0xFC with branch_sel=1 in the fire cycle.
  - With flush=1 in that cycle: branch_sel=0.
- **Flush and saturation:**
  - Stimulus: flush asserted with the slot valid.
  - Required: out_valid=0 the next cycle.
  - Counter check: with CNT_W=2 and a 5-cycle stall, stall_cnt=3.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: instruction field positions, control bundle type and the opcode map
package decode_pkg;
  localparam int REG_AW = 4;
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RS1_HI = 27;
  localparam int RS1_LO = 24;
  localparam int RS2_HI = 23;
  localparam int RS2_LO = 20;
  localparam int RD3_HI = 19;
  localparam int RD3_LO = 16;
  localparam logic [3:0] OP_ALU = 4'd0;
  localparam logic [3:0] OP_ALUI = 4'd1;
  localparam logic [3:0] OP_LD = 4'd2;
  localparam logic [3:0] OP_ST = 4'd3;
  localparam logic [3:0] OP_BR = 4'd4;
  localparam logic [3:0] OP_J = 4'd5;
  localparam logic [3:0] OP_JAL = 4'd6;
  localparam logic [3:0] OP_LUI = 4'd7;
  typedef enum logic [1:0] {IMM_16 = 2'b00, IMM_19 = 2'b01, IMM_27 = 2'b10} imm_sel_t;
  typedef enum logic [1:0] {DST_RS1 = 2'b00, DST_RS2 = 2'b01, DST_RD3 = 2'b10} reg_dst_sel_t;
  typedef struct packed {
    imm_sel_t imm_sel;
    logic branch_type;
    logic branch_sel;
    reg_dst_sel_t reg_dst_sel;
    logic mem_read;
    logic reg_write;
  } ctrl_t;
  localparam ctrl_t CTRL_NOP = '{imm_sel: IMM_16, branch_type: 1'b0, branch_sel: 1'b0,
                                 reg_dst_sel: DST_RS1, mem_read: 1'b0, reg_write: 1'b0};
  function automatic ctrl_t decode_ctrl(input logic [4:0] opcode);
    ctrl_t c;
    c = CTRL_NOP;
    case (opcode[4:1])
      OP_ALU: begin
        c.reg_write = 1'b1;
        c.reg_dst_sel = DST_RD3;
      end
      OP_ALUI: begin
        c.reg_write = 1'b1;
        c.reg_dst_sel = DST_RS2;
      end
      OP_LD: begin
        c.reg_write = 1'b1;
        c.mem_read = 1'b1;
        c.reg_dst_sel = DST_RS2;
      end
      OP_ST: c.imm_sel = IMM_16;
      OP_BR: begin
        c.branch_type = 1'b1;
        c.branch_sel = 1'b1;
      end
      OP_J: begin
        c.branch_sel = 1'b1;
        c.imm_sel = IMM_27;
      end
      OP_JAL: begin
        c.branch_type = 1'b1;
        c.branch_sel = 1'b1;
        c.reg_write = 1'b1;
        c.reg_dst_sel = DST_RD3;
        c.imm_sel = IMM_19;
      end
      OP_LUI: begin
        c.reg_write = 1'b1;
        c.imm_sel = IMM_19;
      end
      default: c = CTRL_NOP;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: IF/ID handshake, writeback, EX hazard info and ID/EX slot bundle
interface decode_stage_if #(parameter int DATA_W = 32, parameter int CNT_W = 16);
  import decode_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [31:0] instr;
  logic [DATA_W-1:0] pc_plus_4;
  logic interrupt;
  logic wr;
  logic [REG_AW-1:0] wr_dst;
  logic [DATA_W-1:0] wr_data;
  logic ex_valid;
  logic ex_mem_read;
  logic [REG_AW-1:0] ex_reg_dst;
  logic flush;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [REG_AW-1:0] rs1_idx;
  logic [REG_AW-1:0] rs2_idx;
  logic [REG_AW-1:0] reg_dst;
  logic [DATA_W-1:0] sign_ext_imm;
  logic [DATA_W-1:0] pc_plus_4_out;
  logic interrupt_out;
  ctrl_t ctrl_out;
  logic [DATA_W-1:0] branch_pc;
  logic branch_sel;
  logic [CNT_W-1:0] stall_cnt;
  modport slave (
    input in_valid, instr, pc_plus_4, interrupt, wr, wr_dst, wr_data,
          ex_valid, ex_mem_read, ex_reg_dst, flush, out_ready,
    output in_ready, out_valid, rd1, rd2, rs1_idx, rs2_idx, reg_dst, sign_ext_imm,
           pc_plus_4_out, interrupt_out, ctrl_out, branch_pc, branch_sel, stall_cnt
  );
  modport master (
    output in_valid, instr, pc_plus_4, interrupt, wr, wr_dst, wr_data,
           ex_valid, ex_mem_read, ex_reg_dst, flush, out_ready,
    input in_ready, out_valid, rd1, rd2, rs1_idx, rs2_idx, reg_dst, sign_ext_imm,
          pc_plus_4_out, interrupt_out, ctrl_out, branch_pc, branch_sel, stall_cnt
  );
endinterface

// File: rtl/regfile_param.sv
// regfile_param: NUM_REGS x DATA_W register file, two async reads, one sync write, optional zero R0
module regfile_param
  import decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 16,
  parameter int R0_ZERO = 1
) (
  input logic clk,
  input logic rst_n,
  input logic we,
  input logic [REG_AW-1:0] wa,
  input logic [DATA_W-1:0] wd,
  input logic [REG_AW-1:0] ra1,
  input logic [REG_AW-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);
  logic [DATA_W-1:0] mem [NUM_REGS];
  logic wa_ok;
  assign wa_ok = 32'(wa) < NUM_REGS && !(R0_ZERO != 0 && wa == '0);
  assign rd1 = (R0_ZERO != 0 && ra1 == '0) || 32'(ra1) >= NUM_REGS ? '0 : mem[ra1];
  assign rd2 = (R0_ZERO != 0 && ra2 == '0) || 32'(ra2) >= NUM_REGS ? '0 : mem[ra2];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we && wa_ok) begin
      mem[wa] <= wd;
    end
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: instruction decode with register file, WB bypass, load-use stall, flush and registered ID/EX slot
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 16,
  parameter int R0_ZERO = 1,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  decode_stage_if.slave bus
);
  logic [4:0] opcode;
  logic [REG_AW-1:0] rs1, rs2, rd3, dst;
  ctrl_t ctrl;
  logic [DATA_W-1:0] imm, rf1, rf2, op1, op2;
  logic wr_ok, hz, fire;
  assign opcode = bus.instr[OPC_HI:OPC_LO];
  assign rs1 = bus.instr[RS1_HI:RS1_LO];
  assign rs2 = bus.instr[RS2_HI:RS2_LO];
  assign rd3 = bus.instr[RD3_HI:RD3_LO];
  assign ctrl = decode_ctrl(opcode);
  assign imm = ctrl.imm_sel == IMM_16 ? DATA_W'($signed(bus.instr[15:0])) :
               ctrl.imm_sel == IMM_19 ? DATA_W'($signed(bus.instr[18:0])) :
               DATA_W'($signed(bus.instr[26:0]));
  assign dst = ctrl.reg_dst_sel == DST_RS1 ? rs1 : ctrl.reg_dst_sel == DST_RS2 ? rs2 : rd3;
  assign wr_ok = bus.wr && !(R0_ZERO != 0 && bus.wr_dst == '0);
  assign op1 = wr_ok && bus.wr_dst == rs1 ? bus.wr_data : rf1;
  assign op2 = wr_ok && bus.wr_dst == rs2 ? bus.wr_data : rf2;
  assign hz = bus.in_valid && bus.ex_valid && bus.ex_mem_read &&
              (bus.ex_reg_dst == rs1 || bus.ex_reg_dst == rs2);
  assign bus.in_ready = rst_n && !bus.flush && !hz && (!bus.out_valid || bus.out_ready);
  assign fire = bus.in_valid && bus.in_ready;
  assign bus.branch_pc = imm + (ctrl.branch_type ? bus.pc_plus_4 : '0);
  assign bus.branch_sel = fire && ctrl.branch_sel;
  regfile_param #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .R0_ZERO(R0_ZERO)) u_rf (
    .clk(clk),
    .rst_n(rst_n),
    .we(bus.wr),
    .wa(bus.wr_dst),
    .wd(bus.wr_data),
    .ra1(rs1),
    .ra2(rs2),
    .rd1(rf1),
    .rd2(rf2)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.rd1 <= '0;
      bus.rd2 <= '0;
      bus.rs1_idx <= '0;
      bus.rs2_idx <= '0;
      bus.reg_dst <= '0;
      bus.sign_ext_imm <= '0;
      bus.pc_plus_4_out <= '0;
      bus.interrupt_out <= 1'b0;
      bus.ctrl_out <= CTRL_NOP;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (fire) begin
      bus.out_valid <= 1'b1;
      bus.rd1 <= op1;
      bus.rd2 <= op2;
      bus.rs1_idx <= rs1;
      bus.rs2_idx <= rs2;
      bus.reg_dst <= dst;
      bus.sign_ext_imm <= imm;
      bus.pc_plus_4_out <= bus.pc_plus_4;
      bus.interrupt_out <= bus.interrupt;
      bus.ctrl_out <= ctrl;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end else if (bus.out_valid) begin
      if (wr_ok && bus.wr_dst == bus.rs1_idx) bus.rd1 <= bus.wr_data;
      if (wr_ok && bus.wr_dst == bus.rs2_idx) bus.rd2 <= bus.wr_data;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) bus.stall_cnt <= '0;
    else if (bus.in_valid && !bus.in_ready && !(&bus.stall_cnt)) bus.stall_cnt <= bus.stall_cnt + 1'b1;
  end
endmodule
